// File: rtl/hilo_sched.sv
// hilo_sched: HI/LO owner and scheduler for MULT/MULTU/DIV/DIVU/MTHI/MTLO
// (plus MADD/MSUB when HILO_MADD_EN is defined).
// Ports: clk, rst (async active-low), op_valid, op[2:0], opa, opb, flush
//        -> stall_o, hi_o, lo_o, div0_o.
module hilo_sched #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div0_o
);

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  localparam logic [5:0] LAST = 6'(DIV_ITERS - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div0_q, div0_d;

  // Single 64x64 multiplier: operands are sign- or zero-extended so the
  // low 64 bits give the correct signed/unsigned product.
  logic        msgn;
  logic [63:0] ea, eb, prod;
  assign msgn = (op != OP_MULTU);
  assign ea   = {{32{msgn & opa[31]}}, opa};
  assign eb   = {{32{msgn & opb[31]}}, opb};
  assign prod = ea * eb;

  logic        sdiv;
  logic [31:0] abs_a, abs_b;
  assign sdiv  = (op == OP_DIV);
  assign abs_a = (sdiv && opa[31]) ? 32'd0 - opa : opa;
  assign abs_b = (sdiv && opb[31]) ? 32'd0 - opb : opb;

  // One restoring step: 33-bit trial keeps the bit shifted out of rem.
  logic [32:0] trial;
  logic        qbit;
  logic [31:0] rem_n, quo_n;
  assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  assign qbit  = ~trial[32];
  assign rem_n = qbit ? trial[31:0] : {rem_q[30:0], quo_q[31]};
  assign quo_n = {quo_q[30:0], qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = 1'b0;
    stall_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          unique case (op)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_MTHI: hi_d = opa;
            OP_MTLO: lo_d = opa;
            OP_DIV, OP_DIVU: begin
              if (opb == 32'd0) begin
                div0_d = 1'b1;
              end else begin
                stall_o = 1'b1;
                state_d = S_DIV;
                cnt_d   = 6'd0;
                rem_d   = 32'd0;
                quo_d   = abs_a;
                dvs_d   = abs_b;
                qneg_d  = sdiv & (opa[31] ^ opb[31]);
                rneg_d  = sdiv & opa[31];
              end
            end
            OP_MADD: begin
`ifdef HILO_MADD_EN
              {hi_d, lo_d} = {hi_q, lo_q} + prod;
`endif
            end
            OP_MSUB: begin
`ifdef HILO_MADD_EN
              {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
            end
          endcase
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          rem_d   = rem_n;
          quo_d   = quo_n;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            lo_d    = qneg_q ? 32'd0 - quo_n : quo_n;
            hi_d    = rneg_q ? 32'd0 - rem_n : rem_n;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign div0_o = div0_q;

endmodule

// File: tb/tb_hilo_sched.sv
// tb_hilo_sched: directed self-checking bench for hilo_sched.
// Inputs change 1 ns after the rising edge; outputs sampled 1 ns later.
module tb_hilo_sched;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div0_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  hilo_sched dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .flush    (flush),
    .stall_o  (stall_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .div0_o   (div0_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op       = 3'b000;
    opa      = 32'd0;
    opb      = 32'd0;
    flush    = 1'b0;
  endtask

  task automatic put(input logic [2:0] o,
                     input logic [31:0] a,
                     input logic [31:0] b);
    cyc();
    op_valid = 1'b1;
    op       = o;
    opa      = a;
    opb      = b;
    #1;
  endtask

  // Issues a divide and counts stall cycles; leaves sampling point in the
  // first non-stalled cycle. Junk MTLO is offered while stalled.
  task automatic do_div(input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int n);
    put(o, a, b);
    n = 0;
    while (stall_o === 1'b1 && n < 40) begin
      n++;
      cyc();
      op_valid = 1'b1;
      op       = 3'b101;
      opa      = 32'hDEADBEEF;
      #1;
    end
    idle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #12;
    tot_cnt++;
    if (hi_o !== 32'd0) $display("FAIL reset_hi got %h exp 0", hi_o);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'd0) $display("FAIL reset_lo got %h exp 0", lo_o);
    else pass_cnt++;
    tot_cnt++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_o);
    else pass_cnt++;
    tot_cnt++;
    if (div0_o !== 1'b0) $display("FAIL reset_div0 got %b exp 0", div0_o);
    else pass_cnt++;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_mult();
    put(3'b000, 32'hFFFFFFFD, 32'd5);
    tot_cnt++;
    if (stall_o !== 1'b0) $display("FAIL mult_stall got %b exp 0", stall_o);
    else pass_cnt++;
    cyc();
    idle();
    #1;
    tot_cnt++;
    if (hi_o !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h exp ffffffff", hi_o);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'hFFFFFFF1) $display("FAIL mult_lo got %h exp fffffff1", lo_o);
    else pass_cnt++;
    put(3'b001, 32'hFFFFFFFF, 32'd2);
    cyc();
    idle();
    #1;
    tot_cnt++;
    if (hi_o !== 32'd1) $display("FAIL multu_hi got %h exp 1", hi_o);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'hFFFFFFFE) $display("FAIL multu_lo got %h exp fffffffe", lo_o);
    else pass_cnt++;
  endtask

  task automatic test_divu();
    int n;
    do_div(3'b011, 32'd100, 32'd7, n);
    tot_cnt++;
    if (n !== 33) $display("FAIL divu_stall_cycles got %0d exp 33", n);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'd14) $display("FAIL divu_lo got %h exp e", lo_o);
    else pass_cnt++;
    tot_cnt++;
    if (hi_o !== 32'd2) $display("FAIL divu_hi got %h exp 2", hi_o);
    else pass_cnt++;
  endtask

  task automatic test_div_signed();
    int n;
    do_div(3'b010, 32'hFFFFFFF9, 32'd2, n);
    tot_cnt++;
    if (lo_o !== 32'hFFFFFFFD) $display("FAIL divs1_lo got %h exp fffffffd", lo_o);
    else pass_cnt++;
    tot_cnt++;
    if (hi_o !== 32'hFFFFFFFF) $display("FAIL divs1_hi got %h exp ffffffff", hi_o);
    else pass_cnt++;
    do_div(3'b010, 32'h80000000, 32'hFFFFFFFF, n);
    tot_cnt++;
    if (lo_o !== 32'h80000000) $display("FAIL divs2_lo got %h exp 80000000", lo_o);
    else pass_cnt++;
    tot_cnt++;
    if (hi_o !== 32'd0) $display("FAIL divs2_hi got %h exp 0", hi_o);
    else pass_cnt++;
    do_div(3'b010, 32'd7, 32'hFFFFFFFE, n);
    tot_cnt++;
    if (lo_o !== 32'hFFFFFFFD) $display("FAIL divs3_lo got %h exp fffffffd", lo_o);
    else pass_cnt++;
    tot_cnt++;
    if (hi_o !== 32'd1) $display("FAIL divs3_hi got %h exp 1", hi_o);
    else pass_cnt++;
  endtask

  task automatic test_div0();
    put(3'b100, 32'h11, 32'd0);
    put(3'b101, 32'h22, 32'd0);
    put(3'b010, 32'd9, 32'd0);
    tot_cnt++;
    if (stall_o !== 1'b0) $display("FAIL div0_stall got %b exp 0", stall_o);
    else pass_cnt++;
    tot_cnt++;
    if (div0_o !== 1'b0) $display("FAIL div0_early got %b exp 0", div0_o);
    else pass_cnt++;
    cyc();
    idle();
    #1;
    tot_cnt++;
    if (div0_o !== 1'b1) $display("FAIL div0_pulse got %b exp 1", div0_o);
    else pass_cnt++;
    tot_cnt++;
    if (hi_o !== 32'h11) $display("FAIL div0_hi got %h exp 11", hi_o);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'h22) $display("FAIL div0_lo got %h exp 22", lo_o);
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if (div0_o !== 1'b0) $display("FAIL div0_once got %b exp 0", div0_o);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    put(3'b011, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      cyc();
      idle();
      if (c == 10) flush = 1'b1;
      #1;
    end
    cyc();
    idle();
    #1;
    tot_cnt++;
    if (stall_o !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall_o);
    else pass_cnt++;
    repeat (30) cyc();
    tot_cnt++;
    if (hi_o !== 32'h11) $display("FAIL flush_hi got %h exp 11", hi_o);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'h22) $display("FAIL flush_lo got %h exp 22", lo_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    put(3'b011, 32'd100, 32'd7);
    for (int c = 1; c < 20; c++) begin
      cyc();
      idle();
    end
    cyc();
    rst = 1'b0;
    #1;
    tot_cnt++;
    if (hi_o !== 32'd0) $display("FAIL rstmid_hi got %h exp 0", hi_o);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'd0) $display("FAIL rstmid_lo got %h exp 0", lo_o);
    else pass_cnt++;
    tot_cnt++;
    if (stall_o !== 1'b0) $display("FAIL rstmid_stall got %b exp 0", stall_o);
    else pass_cnt++;
    cyc();
    rst = 1'b1;
    repeat (20) cyc();
    tot_cnt++;
    if (stall_o !== 1'b0) $display("FAIL rstmid_idle got %b exp 0", stall_o);
    else pass_cnt++;
    tot_cnt++;
    if ({hi_o, lo_o} !== 64'd0) $display("FAIL rstmid_nowrite got %h exp 0", {hi_o, lo_o});
    else pass_cnt++;
  endtask

  task automatic test_madd();
    logic [31:0] eh1, el1, eh2, el2;
`ifdef HILO_MADD_EN
    eh1 = 32'd1; el1 = 32'd0;
    eh2 = 32'd0; el2 = 32'hFFFFFFFF;
`else
    eh1 = 32'd0; el1 = 32'hFFFFFFFF;
    eh2 = 32'd0; el2 = 32'hFFFFFFFF;
`endif
    put(3'b100, 32'd0, 32'd0);
    put(3'b101, 32'hFFFFFFFF, 32'd0);
    put(3'b110, 32'd1, 32'd1);
    tot_cnt++;
    if (stall_o !== 1'b0) $display("FAIL madd_stall got %b exp 0", stall_o);
    else pass_cnt++;
    cyc();
    idle();
    #1;
    tot_cnt++;
    if (hi_o !== eh1) $display("FAIL madd_hi got %h exp %h", hi_o, eh1);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== el1) $display("FAIL madd_lo got %h exp %h", lo_o, el1);
    else pass_cnt++;
    put(3'b111, 32'd1, 32'd1);
    cyc();
    idle();
    #1;
    tot_cnt++;
    if (hi_o !== eh2) $display("FAIL msub_hi got %h exp %h", hi_o, eh2);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== el2) $display("FAIL msub_lo got %h exp %h", lo_o, el2);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    put(3'b000, 32'd3, 32'd4);
    put(3'b001, 32'h10000, 32'h10000);
    tot_cnt++;
    if (lo_o !== 32'd12) $display("FAIL b2b_first_lo got %h exp c", lo_o);
    else pass_cnt++;
    cyc();
    idle();
    #1;
    tot_cnt++;
    if (hi_o !== 32'd1) $display("FAIL b2b_hi got %h exp 1", hi_o);
    else pass_cnt++;
    tot_cnt++;
    if (lo_o !== 32'd0) $display("FAIL b2b_lo got %h exp 0", lo_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_div_signed();
    test_div0();
    test_flush();
    test_reset_mid();
    test_madd();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/hilo_sched.md
# hilo_sched

Scheduler and owner of the HI/LO register pair for the five-stage pipeline. It accepts multiply, divide and move-to-HI/LO operations from the EX stage and runs a 1-cycle multiply or a 32-iteration radix-2 restoring divider. It raises a stall while a divide is in flight and commits results to HI/LO atomically, so MFHI/MFLO read consistent values straight from `hi_o`/`lo_o`.

## Interface
Parameters:
- `DIV_ITERS`, 32, divider iterations; fixed to the data width, not user-tunable.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  EX stage presents an operation this cycle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- `opa`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `opb`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  pipeline flush; cancels an in-flight divide.
- `stall_o`  out  1  hold EX and earlier stages.
- `hi_o`  out  32  current HI.
- `lo_o`  out  32  current LO.
- `div0_o`  out  1  one-cycle pulse when a divide by zero completes.

## Operation
States: IDLE, DIV.
- IDLE accepts an operation when `op_valid`=1 and `flush`=0.
  - MULT/MULTU: writes the 64-bit signed/unsigned product, {HI,LO} = opa*opb.
  - MTHI/MTLO: write `opa` to HI or LO; the other register is unchanged.
  - MADD/MSUB (macro only): {HI,LO} = {HI,LO} ± signed(opa*opb), modulo 2^64.
  - DIV/DIVU, `opb`≠0: latch |opa| and |opb| (raw values for DIVU), the quotient sign (opa[31]^opb[31]) and the remainder sign (opa[31]); clear the 6-bit counter and the remainder; go to DIV.
  - DIV/DIVU, `opb`=0: no state change; HI/LO unchanged; `div0_o` pulses on the next cycle.
- DIV performs one restoring step per cycle: shift {rem, quo} left, trial-subtract the divisor, set the quotient bit when the result is non-negative. The counter increments each step.
- When the counter reaches 31 (the 32nd step), the block applies signs and writes LO = quotient and HI = remainder in the same edge, then returns to IDLE.
- Signed results truncate toward zero: the remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
- `flush` in DIV: return to IDLE on the next edge; HI/LO are untouched; the partial result is discarded.
- `op_valid` during DIV is ignored. Upstream holds the instruction because `stall_o`=1.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, HI=0, LO=0, counter=0, `stall_o`=0, `div0_o`=0, `hi_o`=`lo_o`=0.
- MULT/MTHI/MTLO/MADD/MSUB accepted in cycle t: HI/LO updated at the end of t and visible on `hi_o`/`lo_o` in t+1. There is no stall.
- DIV accepted in cycle 0:
  - `stall_o` is asserted combinationally from cycle 0 through cycle 32 (33 cycles).
  - Steps run in cycles 1–32; the write occurs at the end of cycle 32.
  - `stall_o`=0 and the result is visible in cycle 33.
- `stall_o` = (IDLE & `op_valid` & op∈{DIV,DIVU} & `opb`≠0 & !`flush`) | (DIV & !`flush`).
- Simultaneous `flush` and divide accept: not accepted, and `stall_o`=0.
- Reset asserted mid-divide: immediate return to the reset values listed above. No partial write.
- `hi_o`/`lo_o` are pure register outputs; WB-stage forwarding to MFHI/MFLO is outside this block.

## Configuration
- `HILO_MADD_EN` defined: op codes 110/111 perform MADD/MSUB as specified in Operation.
- `HILO_MADD_EN` undefined: op codes 110/111 are accepted as no-ops, HI/LO are unchanged, no stall, and no accumulate adder is synthesized.

## Test plan
- MULT opa=0xFFFFFFFD, opb=5 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1; `stall_o` never high.
- DIVU opa=100, opb=7 -> `stall_o` high exactly 33 cycles; in cycle 33 LO=14, HI=2.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV opa=9, opb=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO -> `div0_o` pulses once; HI=0x11, LO=0x22; no stall.
- DIVU 100/7 with `flush` in cycle 10 -> `stall_o` low from cycle 11, HI/LO keep prior values; in a separate run, `rst`=0 in cycle 20 -> HI=LO=0 immediately, state IDLE.
- With `HILO_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADD opa=1, opb=1 -> HI=1, LO=0. Without the macro, the same stimulus leaves HI/LO unchanged.
